// File: rtl/mem_access_arbiter_pkg.sv
// Shared encodings for the MEM-stage Dcache arbiter:
// load/store types, access width codes and FSM states.
package mem_access_arbiter_pkg;

  localparam logic [2:0] LD_XXX = 3'd0;
  localparam logic [2:0] LB     = 3'd1;
  localparam logic [2:0] LH     = 3'd2;
  localparam logic [2:0] LW     = 3'd3;
  localparam logic [2:0] LBU    = 3'd4;
  localparam logic [2:0] LHU    = 3'd5;

  localparam logic [1:0] ST_XXX = 2'd0;
  localparam logic [1:0] SB     = 2'd1;
  localparam logic [1:0] SH     = 2'd2;
  localparam logic [1:0] SW     = 2'd3;

  localparam logic [1:0] WID_B  = 2'b00;
  localparam logic [1:0] WID_H  = 2'b01;
  localparam logic [1:0] WID_W  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  // Half needs an even address, word a 4-byte aligned one.
  function automatic logic misaligned(
    input logic [1:0] width,
    input logic [1:0] offset
  );
    return (width == WID_H && offset[0]) ||
           (width == WID_W && offset != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_arbiter_load_align.sv
// Picks the addressed byte/half out of the response word
// and sign- or zero-extends it according to the load type.
module mem_load_align
  import mem_access_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int LD_TYPE_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0]    rsp_data,
  input  logic [1:0]               offset,
  input  logic [LD_TYPE_WIDTH-1:0] ld_type,
  output logic [DATA_WIDTH-1:0]    data
);

  logic [7:0]  b;
  logic [15:0] h;

  // Slice by address offset, then extend by load type.
  always_comb begin
    b    = rsp_data[{offset, 3'b000} +: 8];
    h    = offset[1] ? rsp_data[31:16] : rsp_data[15:0];
    data = rsp_data;
    case (ld_type)
      LD_TYPE_WIDTH'(LB):  data = {{(DATA_WIDTH-8){b[7]}}, b};
      LD_TYPE_WIDTH'(LBU): data = {{(DATA_WIDTH-8){1'b0}}, b};
      LD_TYPE_WIDTH'(LH):  data = {{(DATA_WIDTH-16){h[15]}}, h};
      LD_TYPE_WIDTH'(LHU): data = {{(DATA_WIDTH-16){1'b0}}, h};
      default:             data = rsp_data;
    endcase
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Serialises an N-lane EX/MEM bundle onto one Dcache port.
// Optional MEM_MISALIGN_CHECK_EN drops misaligned half/word lanes.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int LANES         = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int LD_TYPE_WIDTH = 3,
  parameter int ST_TYPE_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          EXMem_Valid,
  input  logic [LANES*LD_TYPE_WIDTH-1:0] EXMem_LdType,
  input  logic [LANES*ST_TYPE_WIDTH-1:0] EXMem_StType,
  input  logic [LANES*DATA_WIDTH-1:0]   EXMem_AluData,
  input  logic [LANES*DATA_WIDTH-1:0]   EXMem_Rs2Data,
  input  logic                          Csr_Memflush,
  output logic                          Mem_Stall,
  output logic                          Mem_ReqValid,
  input  logic                          Mem_ReqReady,
  output logic                          Mem_ReqRd,
  output logic [1:0]                    Mem_ReqWidth,
  output logic [ADDR_WIDTH-1:0]         Mem_ReqAddr,
  output logic [DATA_WIDTH-1:0]         Mem_ReqWdata,
  input  logic                          Mem_RspValid,
  input  logic [DATA_WIDTH-1:0]         Mem_RspData,
  output logic [LANES*DATA_WIDTH-1:0]   Mem_LaneData,
  output logic                          Mem_Done
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic [LANES-1:0]              Mem_Misalign
`endif
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_t state, state_nx;

  logic [LD_TYPE_WIDTH-1:0] ld_q  [LANES];
  logic [ST_TYPE_WIDTH-1:0] st_q  [LANES];
  logic [DATA_WIDTH-1:0]    alu_q [LANES];
  logic [DATA_WIDTH-1:0]    rs2_q [LANES];

  logic [LANES-1:0]            pending, rest;
  logic [LANES-1:0]            mem_in, mis_in, cap_mask;
  logic [LANES*DATA_WIDTH-1:0] lane_data;
  logic                        flushed;
  logic                        capture, rsp_take, kill;
  logic                        req_valid, done, stall;
  logic [IDX_W-1:0]            cur;
  logic                        cur_load;
  logic [1:0]                  cur_width;
  logic [DATA_WIDTH-1:0]       cur_alu, cur_rs2;
  logic [DATA_WIDTH-1:0]       wdata, load_data;

  function automatic logic [1:0] acc_width(
    input logic [LD_TYPE_WIDTH-1:0] ld,
    input logic [ST_TYPE_WIDTH-1:0] st
  );
    logic [1:0] w;
    w = WID_W;
    if (ld != '0) begin
      if (ld == LD_TYPE_WIDTH'(LB) || ld == LD_TYPE_WIDTH'(LBU))
        w = WID_B;
      else if (ld == LD_TYPE_WIDTH'(LH) || ld == LD_TYPE_WIDTH'(LHU))
        w = WID_H;
    end else if (st == ST_TYPE_WIDTH'(SB)) begin
      w = WID_B;
    end else if (st == ST_TYPE_WIDTH'(SH)) begin
      w = WID_H;
    end
    return w;
  endfunction

  // Per-lane memory-op mask of the incoming bundle.
  always_comb begin
    mem_in = '0;
    mis_in = '0;
    for (int i = 0; i < LANES; i++) begin
      mem_in[i] =
        (EXMem_LdType[i*LD_TYPE_WIDTH +: LD_TYPE_WIDTH] != '0) ||
        (EXMem_StType[i*ST_TYPE_WIDTH +: ST_TYPE_WIDTH] != '0);
`ifdef MEM_MISALIGN_CHECK_EN
      mis_in[i] = mem_in[i] && misaligned(
        acc_width(EXMem_LdType[i*LD_TYPE_WIDTH +: LD_TYPE_WIDTH],
                  EXMem_StType[i*ST_TYPE_WIDTH +: ST_TYPE_WIDTH]),
        EXMem_AluData[i*DATA_WIDTH +: 2]);
`endif
    end
    cap_mask = mem_in & ~mis_in;
  end

  // Lowest pending lane is the oldest, so it goes first.
  always_comb begin
    cur = '0;
    for (int i = LANES - 1; i >= 0; i--)
      if (pending[i]) cur = IDX_W'(i);
  end

  assign cur_alu   = alu_q[cur];
  assign cur_rs2   = rs2_q[cur];
  assign cur_load  = ld_q[cur] != '0;
  assign cur_width = acc_width(ld_q[cur], st_q[cur]);
  assign rest      = pending & ~(LANES'(1) << cur);
  assign rsp_take  = (state == S_WAIT) && Mem_RspValid;
  assign kill      = flushed || Csr_Memflush;

  // Store data replicated across the byte lanes of the bus.
  always_comb begin
    case (cur_width)
      WID_B:   wdata = {(DATA_WIDTH/8){cur_rs2[7:0]}};
      WID_H:   wdata = {(DATA_WIDTH/16){cur_rs2[15:0]}};
      default: wdata = cur_rs2;
    endcase
  end

  mem_load_align #(
    .DATA_WIDTH    (DATA_WIDTH),
    .LD_TYPE_WIDTH (LD_TYPE_WIDTH)
  ) u_align (
    .rsp_data (Mem_RspData),
    .offset   (cur_alu[1:0]),
    .ld_type  (ld_q[cur]),
    .data     (load_data)
  );

  // Next state, request valid, stall and done pulse.
  always_comb begin
    state_nx  = state;
    capture   = 1'b0;
    req_valid = 1'b0;
    done      = 1'b0;
    stall     = 1'b0;
    unique case (state)
      S_IDLE: begin
        stall = EXMem_Valid && (cap_mask != '0);
        if (EXMem_Valid && !Csr_Memflush) begin
          capture  = 1'b1;
          state_nx = (cap_mask != '0) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (Csr_Memflush) begin
          state_nx = S_IDLE;
        end else begin
          req_valid = 1'b1;
          if (Mem_ReqReady) state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (Mem_RspValid) begin
          if (kill)              state_nx = S_IDLE;
          else if (rest != '0)   state_nx = S_REQ;
          else                   state_nx = S_DONE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, pending mask, flush flag and writeback slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pending   <= '0;
      flushed   <= 1'b0;
      lane_data <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        pending   <= cap_mask;
        flushed   <= 1'b0;
        lane_data <= EXMem_AluData;
      end else if (rsp_take) begin
        pending <= rest;
        if (!kill && cur_load)
          lane_data[cur*DATA_WIDTH +: DATA_WIDTH] <= load_data;
      end else if (state == S_WAIT && Csr_Memflush) begin
        flushed <= 1'b1;
      end
    end
  end

  // Bundle operands captured once per bundle.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < LANES; i++) begin
        ld_q[i]  <= EXMem_LdType[i*LD_TYPE_WIDTH +: LD_TYPE_WIDTH];
        st_q[i]  <= EXMem_StType[i*ST_TYPE_WIDTH +: ST_TYPE_WIDTH];
        alu_q[i] <= EXMem_AluData[i*DATA_WIDTH +: DATA_WIDTH];
        rs2_q[i] <= EXMem_Rs2Data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic [LANES-1:0] mis_q;

  // Misalign flags live from capture to the next capture.
  always_ff @(posedge clk) begin
    if (!rst_n)       mis_q <= '0;
    else if (capture) mis_q <= mis_in;
  end

  assign Mem_Misalign = mis_q;
`endif

  assign Mem_Stall    = stall;
  assign Mem_Done     = done;
  assign Mem_LaneData = lane_data;
  assign Mem_ReqValid = req_valid;
  assign Mem_ReqRd    = req_valid && cur_load;
  assign Mem_ReqWidth = req_valid ? cur_width : 2'b00;
  assign Mem_ReqAddr  = req_valid ? ADDR_WIDTH'(cur_alu) : '0;
  assign Mem_ReqWdata = (req_valid && !cur_load) ? wdata : '0;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter (LANES=2): directed plan
// plus random bundles against a behavioural model.
module tb_mem_access_arbiter;

  localparam int L = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          EXMem_Valid = 1'b0;
  logic [L*3-1:0]  EXMem_LdType = '0;
  logic [L*2-1:0]  EXMem_StType = '0;
  logic [L*32-1:0] EXMem_AluData = '0;
  logic [L*32-1:0] EXMem_Rs2Data = '0;
  logic          Csr_Memflush = 1'b0;
  logic          Mem_ReqReady = 1'b0;
  logic          Mem_RspValid = 1'b0;
  logic [31:0]   Mem_RspData = '0;
  logic          Mem_Stall, Mem_ReqValid, Mem_ReqRd, Mem_Done;
  logic [1:0]    Mem_ReqWidth;
  logic [31:0]   Mem_ReqAddr, Mem_ReqWdata;
  logic [L*32-1:0] Mem_LaneData;
`ifdef MEM_MISALIGN_CHECK_EN
  logic [L-1:0]  Mem_Misalign;
`endif

  int passed = 0;
  int total  = 0;

  logic [2:0]  b_ld  [L];
  logic [1:0]  b_st  [L];
  logic [31:0] b_alu [L];
  logic [31:0] b_rs2 [L];
  logic [31:0] b_rsp [L];
  logic [63:0] last_lane = '0;

  mem_access_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .EXMem_Valid   (EXMem_Valid),
    .EXMem_LdType  (EXMem_LdType),
    .EXMem_StType  (EXMem_StType),
    .EXMem_AluData (EXMem_AluData),
    .EXMem_Rs2Data (EXMem_Rs2Data),
    .Csr_Memflush  (Csr_Memflush),
    .Mem_Stall     (Mem_Stall),
    .Mem_ReqValid  (Mem_ReqValid),
    .Mem_ReqReady  (Mem_ReqReady),
    .Mem_ReqRd     (Mem_ReqRd),
    .Mem_ReqWidth  (Mem_ReqWidth),
    .Mem_ReqAddr   (Mem_ReqAddr),
    .Mem_ReqWdata  (Mem_ReqWdata),
    .Mem_RspValid  (Mem_RspValid),
    .Mem_RspData   (Mem_RspData),
    .Mem_LaneData  (Mem_LaneData),
    .Mem_Done      (Mem_Done)
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    .Mem_Misalign  (Mem_Misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Model: access size in bytes-code (0=byte,1=half,2=word).
  function automatic logic [1:0] m_width(input logic [2:0] ld,
                                         input logic [1:0] st);
    if (ld != 0) begin
      if (ld == 1 || ld == 4) return 2'd0;
      if (ld == 2 || ld == 5) return 2'd1;
      return 2'd2;
    end
    if (st == 1) return 2'd0;
    if (st == 2) return 2'd1;
    return 2'd2;
  endfunction

  // Model: load result from response word by arithmetic.
  function automatic logic [31:0] m_ext(input logic [2:0] t,
                                        input logic [31:0] w,
                                        input logic [31:0] a);
    int unsigned b, h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (t)
      3'd1:    return (b >= 128) ? b - 256 : b;
      3'd4:    return b;
      3'd2:    return (h >= 32768) ? h - 65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] w,
                                          input logic [31:0] d);
    if (w == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (w == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit m_mis(input logic [1:0] w,
                               input logic [31:0] a);
    return (w == 1 && (a % 2) != 0) || (w == 2 && (a % 4) != 0);
  endfunction

  task automatic drive_bundle();
    for (int i = 0; i < L; i++) begin
      EXMem_LdType[i*3 +: 3]   = b_ld[i];
      EXMem_StType[i*2 +: 2]   = b_st[i];
      EXMem_AluData[i*32 +: 32] = b_alu[i];
      EXMem_Rs2Data[i*32 +: 32] = b_rs2[i];
    end
    EXMem_Valid = 1'b1;
  endtask

  // Runs one bundle from IDLE to retire, checking every step.
  task automatic run_bundle(input string nm,
                            input int rdy_d,
                            input int rsp_d);
    int          q[$];
    logic [31:0] exp_lane [L];
    logic [L-1:0] exp_mis;
    logic [1:0]  w;
    int          ln;
    bit          isld;
    exp_mis = '0;
    for (int i = 0; i < L; i++) begin
      exp_lane[i] = b_alu[i];
      if (b_ld[i] != 0 || b_st[i] != 0) begin
        w = m_width(b_ld[i], b_st[i]);
`ifdef MEM_MISALIGN_CHECK_EN
        if (m_mis(w, b_alu[i])) begin
          exp_mis[i] = 1'b1;
          continue;
        end
`endif
        q.push_back(i);
      end
    end
    drive_bundle();
    #1;
    check({nm, "_stall_cap"}, Mem_Stall, q.size() != 0);
    tick();
    EXMem_Valid = 1'b0;
    foreach (q[k]) begin
      ln   = q[k];
      isld = b_ld[ln] != 0;
      w    = m_width(b_ld[ln], b_st[ln]);
      for (int d = 0; d <= rdy_d; d++) begin
        Mem_ReqReady = (d == rdy_d);
        #1;
        check({nm, "_rv"}, Mem_ReqValid, 1'b1);
        check({nm, "_rd"}, Mem_ReqRd, isld);
        check({nm, "_wid"}, Mem_ReqWidth, w);
        check({nm, "_addr"}, Mem_ReqAddr, b_alu[ln]);
        check({nm, "_stall"}, Mem_Stall, 1'b1);
        if (!isld)
          check({nm, "_wdata"}, Mem_ReqWdata,
                m_wdata(w, b_rs2[ln]));
        tick();
      end
      Mem_ReqReady = 1'b0;
      for (int j = 0; j < rsp_d; j++) begin
        check({nm, "_wait_rv"}, Mem_ReqValid, 1'b0);
        tick();
      end
      Mem_RspValid = 1'b1;
      Mem_RspData  = b_rsp[k];
      tick();
      Mem_RspValid = 1'b0;
      Mem_RspData  = $urandom;
      if (isld) exp_lane[ln] = m_ext(b_ld[ln], b_rsp[k], b_alu[ln]);
    end
    check({nm, "_done"}, Mem_Done, 1'b1);
    check({nm, "_done_stall"}, Mem_Stall, 1'b0);
    check({nm, "_done_rv"}, Mem_ReqValid, 1'b0);
    check({nm, "_lanes"}, Mem_LaneData, {exp_lane[1], exp_lane[0]});
`ifdef MEM_MISALIGN_CHECK_EN
    check({nm, "_mis"}, Mem_Misalign, exp_mis);
`endif
    tick();
    check({nm, "_done_off"}, Mem_Done, 1'b0);
    check({nm, "_hold"}, Mem_LaneData, {exp_lane[1], exp_lane[0]});
    last_lane = {exp_lane[1], exp_lane[0]};
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_rv", Mem_ReqValid, 1'b0);
    check("rst_done", Mem_Done, 1'b0);
    check("rst_lanes", Mem_LaneData, 64'h0);
    check("rst_stall", Mem_Stall, 1'b0);
    rst_n = 1'b1;
    tick();

    // LB + SW
    b_ld  = '{3'd1, 3'd0};
    b_st  = '{2'd0, 2'd3};
    b_alu = '{32'h1003, 32'h2000};
    b_rs2 = '{32'h0, 32'hDEAD_BEEF};
    b_rsp = '{32'h80FF_FF7F, 32'h0};
    run_bundle("lb_sw", 0, 0);
    check("lb_sw_lane0", Mem_LaneData[31:0], 32'hFFFF_FF80);

    // No memory ops
    b_ld  = '{3'd0, 3'd0};
    b_st  = '{2'd0, 2'd0};
    b_alu = '{32'h5, 32'h7};
    run_bundle("nomem", 0, 0);

    // Flush together with valid in IDLE: no capture
    b_ld  = '{3'd3, 3'd0};
    b_alu = '{32'h40, 32'h44};
    drive_bundle();
    Csr_Memflush = 1'b1;
    tick();
    EXMem_Valid  = 1'b0;
    Csr_Memflush = 1'b0;
    check("flidle_rv", Mem_ReqValid, 1'b0);
    check("flidle_lanes", Mem_LaneData, last_lane);
    tick();
    check("flidle_done", Mem_Done, 1'b0);

    // LHU with ready held low
    b_ld  = '{3'd5, 3'd0};
    b_st  = '{2'd0, 2'd0};
    b_alu = '{32'h0102, 32'h9};
    b_rsp = '{32'hABCD_1234, 32'h0};
    run_bundle("lhu", 3, 1);
    check("lhu_lane0", Mem_LaneData[31:0], 32'h0000_ABCD);

    // Flush in WAIT
    b_ld  = '{3'd3, 3'd0};
    b_alu = '{32'h300, 32'h304};
    drive_bundle();
    tick();
    EXMem_Valid  = 1'b0;
    Mem_ReqReady = 1'b1;
    tick();
    Mem_ReqReady = 1'b0;
    Csr_Memflush = 1'b1;
    tick();
    Csr_Memflush = 1'b0;
    check("flwait_stall", Mem_Stall, 1'b1);
    Mem_RspValid = 1'b1;
    tick();
    Mem_RspValid = 1'b0;
    check("flwait_done", Mem_Done, 1'b0);
    check("flwait_idle_stall", Mem_Stall, 1'b0);
    check("flwait_rv", Mem_ReqValid, 1'b0);
    tick();
    check("flwait_done2", Mem_Done, 1'b0);
    b_ld  = '{3'd2, 3'd1};
    b_alu = '{32'h402, 32'h407};
    b_rsp = '{32'h8001_0000, 32'h7F00_0000};
    run_bundle("after_flwait", 0, 0);

    // Flush in REQ
    b_ld  = '{3'd0, 3'd0};
    b_st  = '{2'd1, 2'd0};
    b_alu = '{32'h500, 32'h504};
    drive_bundle();
    tick();
    EXMem_Valid = 1'b0;
    check("flreq_rv_pre", Mem_ReqValid, 1'b1);
    Csr_Memflush = 1'b1;
    #1;
    check("flreq_rv_drop", Mem_ReqValid, 1'b0);
    tick();
    Csr_Memflush = 1'b0;
    check("flreq_rv_post", Mem_ReqValid, 1'b0);
    check("flreq_done", Mem_Done, 1'b0);
    tick();
    check("flreq_done2", Mem_Done, 1'b0);

    // Reset during REQ, then a stray response
    b_ld  = '{3'd3, 3'd0};
    b_st  = '{2'd0, 2'd0};
    b_alu = '{32'h600, 32'h604};
    drive_bundle();
    tick();
    EXMem_Valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstreq_rv", Mem_ReqValid, 1'b0);
    check("rstreq_lanes", Mem_LaneData, 64'h0);
    Mem_RspValid = 1'b1;
    tick();
    Mem_RspValid = 1'b0;
    check("stray_rv", Mem_ReqValid, 1'b0);
    check("stray_done", Mem_Done, 1'b0);
    check("stray_stall", Mem_Stall, 1'b0);
    tick();
    check("stray_done2", Mem_Done, 1'b0);

`ifdef MEM_MISALIGN_CHECK_EN
    // Misaligned word load is skipped but still retires
    b_ld  = '{3'd3, 3'd0};
    b_st  = '{2'd0, 2'd0};
    b_alu = '{32'h1002, 32'h8};
    run_bundle("mis_lw", 0, 0);
    check("mis_lw_bit", Mem_Misalign[0], 1'b1);
`endif

    // Random bundles
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < L; i++) begin
        b_ld[i]  = ($urandom_range(0, 1) != 0) ?
                   3'($urandom_range(1, 5)) : 3'd0;
        b_st[i]  = 2'($urandom_range(0, 3));
        b_alu[i] = $urandom;
        b_rs2[i] = $urandom;
        b_rsp[i] = $urandom;
      end
      run_bundle("rnd", $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
